// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared types and constants for the countdown controller.
//   state_e    : controller states (IDLE, RUN, DONE)
//   SEG_BLANK  : all segments off (active-low)
//   SEG_DIGITS : active-low 7-segment patterns for 0..9, bit order gfedcba
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/countdown_if.sv
// countdown_if
// Board-side signal bundle of the countdown controller.
//   start     : synchronous level; while high the preset is (re)loaded
//   dec       : raw active-low push-button, asynchronous and bouncy
//   num       : preset value, sampled only on load
//   count     : current counter value
//   done      : high while the controller sits at terminal count
//   segA/segB : tens/units digits, active-low, gfedcba
//   dbg_state : current controller state, for observation only
//   auto_mode : (COUNTDOWN_AUTO_DEC_EN only) enables timed auto-decrement
// There is no valid/ready handshake: start is a plain level sampled every
// clock, and dec is an asynchronous level conditioned inside the block.
// Modports: master = board/bench side, slave = controller side.
interface countdown_if
    import countdown_pkg::*;
#(
    parameter int N = 4
) ();

    logic         start;
    logic         dec;
    logic [N-1:0] num;
    logic [N-1:0] count;
    logic         done;
    logic [6:0]   segA;
    logic [6:0]   segB;
    state_e       dbg_state;
`ifdef COUNTDOWN_AUTO_DEC_EN
    logic         auto_mode;
`endif

    modport master (
        output start, dec, num,
`ifdef COUNTDOWN_AUTO_DEC_EN
        output auto_mode,
`endif
        input  count, done, segA, segB, dbg_state
    );

    modport slave (
        input  start, dec, num,
`ifdef COUNTDOWN_AUTO_DEC_EN
        input  auto_mode,
`endif
        output count, done, segA, segB, dbg_state
    );

endinterface

// File: rtl/countdown_ctrl_seg7_decoder.sv
// seg7_decoder
// Converts one BCD digit to an active-low 7-segment pattern (gfedcba).
//   digit : 4-bit digit in; values above 9 blank the display
//   seg   : 7-bit active-low segment drive
module seg7_decoder
    import countdown_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = SEG_DIGITS[digit];
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl
// Loadable down-counter driven by a debounced push-button, with terminal
// count detection and a two-digit 7-segment display.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : countdown_if.slave (start, dec, num in; count, done, segA, segB,
//         dbg_state out)
// Parameters: N (counter width, 1..6), DB_CYCLES (debounce length, >= 2).
// Optional build macro COUNTDOWN_AUTO_DEC_EN adds parameter TICK_CYCLES and
// input bus.auto_mode: a prescaler tick that decrements like a button press.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int N         = 4,
    parameter int DB_CYCLES = 50000
`ifdef COUNTDOWN_AUTO_DEC_EN
    ,
    parameter int TICK_CYCLES = 50_000_000
`endif
) (
    input logic      clk,
    input logic      rst,
    countdown_if.slave bus
);

    localparam int DB_W = $clog2(DB_CYCLES);

    // Input conditioning registers
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_level_q, db_level_d;
    logic            dec_pulse_q, dec_pulse_d;

    // Controller registers
    state_e          state_q, state_d;
    logic [N-1:0]    count_q, count_d;

    logic            dec_event;

`ifdef COUNTDOWN_AUTO_DEC_EN
    localparam int TK_W = $clog2(TICK_CYCLES);
    logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic            tick;

    assign tick = (state_q == RUN) && bus.auto_mode &&
                  (tick_cnt_q == TK_W'(TICK_CYCLES - 1));

    // Tick and button in the same cycle still give a single decrement.
    assign dec_event = dec_pulse_q | tick;
`else
    assign dec_event = dec_pulse_q;
`endif

    // Synchroniser and debouncer. The debounced level only moves after the
    // synchronised input has differed from it for DB_CYCLES samples in a
    // row; falling back to the old level restarts the count. The pulse
    // fires only on an accepted press (new level 0), never on release.
    always_comb begin
        sync1_d     = bus.dec;
        sync2_d     = sync1_q;
        db_cnt_d    = db_cnt_q;
        db_level_d  = db_level_q;
        dec_pulse_d = 1'b0;
        if (sync2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
            db_cnt_d    = '0;
            db_level_d  = sync2_q;
            dec_pulse_d = ~sync2_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Next-state and counter logic. start wins over a decrement; DONE holds
    // the count at zero so the counter never wraps.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    count_d = bus.num;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.start) begin
                    count_d = bus.num;
                end else if (count_q == '0) begin
                    // Covers a zero preset: one cycle in RUN, then DONE.
                    state_d = DONE;
                end else if (dec_event) begin
                    count_d = count_q - 1'b1;
                    if (count_q == N'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                count_d = '0;
                if (bus.start) begin
                    count_d = bus.num;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

`ifdef COUNTDOWN_AUTO_DEC_EN
    // Prescaler restarts on every load and on entry to DONE so each run
    // starts with a full TICK_CYCLES interval.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (bus.start || (state_d == DONE && state_q != DONE)) begin
            tick_cnt_d = '0;
        end else if (state_q == RUN && bus.auto_mode) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end
`endif

    // Synchroniser and debounced level reset to the released (high) level
    // so a press in flight at reset is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            db_cnt_q    <= '0;
            db_level_q  <= 1'b1;
            dec_pulse_q <= 1'b0;
            state_q     <= IDLE;
            count_q     <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_cnt_q    <= db_cnt_d;
            db_level_q  <= db_level_d;
            dec_pulse_q <= dec_pulse_d;
            state_q     <= state_d;
            count_q     <= count_d;
        end
    end

    // Display: count is at most 63, so 7 bits hold it and both quotient
    // and remainder fit a 4-bit digit.
    logic [6:0] count_ext;
    logic [3:0] tens;
    logic [3:0] units;
    logic [6:0] seg_tens;
    logic [6:0] seg_units;

    assign count_ext = 7'(count_q);
    assign tens      = 4'(count_ext / 7'd10);
    assign units     = 4'(count_ext % 7'd10);

    seg7_decoder u_seg_tens (
        .digit (tens),
        .seg   (seg_tens)
    );

    seg7_decoder u_seg_units (
        .digit (units),
        .seg   (seg_units)
    );

    assign bus.count     = count_q;
    assign bus.done      = (state_q == DONE);
    assign bus.segA      = seg_tens;
    assign bus.segB      = seg_units;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl
// Self-checking bench for countdown_ctrl with DB_CYCLES=4: directed cases
// followed by randomized start/press/bounce/idle operations compared
// against a transaction-level model of the counter.
module tb_countdown_ctrl;

    localparam int N  = 4;
    localparam int DB = 4;

    logic clk;
    logic rst;

    countdown_if #(.N(N)) bus ();

    countdown_ctrl #(
        .N         (N),
        .DB_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    // Scoreboard counters
    int n_vec = 0;
    int n_err = 0;

    // Model: 0 = idle, 1 = run, 2 = done
    int m_st  = 0;
    int m_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".count"}, 32'(bus.count), 32'(m_cnt));
        check_eq({tag, ".done"},  32'(bus.done),  32'(m_st == 2));
        check_eq({tag, ".segA"},  32'(bus.segA),  32'(seg_of(m_cnt / 10)));
        check_eq({tag, ".segB"},  32'(bus.segB),  32'(seg_of(m_cnt % 10)));
    endtask

    // Driver tasks (inputs change just after the falling edge)
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int v);
        bus.num   = 4'(v);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(2);
        m_cnt = v;
        m_st  = (v == 0) ? 2 : 1;
    endtask

    task automatic m_press();
        if (m_st == 1 && m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_st = 2;
        end
    endtask

    task automatic press_clean(input int hold, input int rel);
        bus.dec = 1'b0;
        tick(hold);
        bus.dec = 1'b1;
        tick(rel);
        m_press();
    endtask

    task automatic press_bouncy(input int runs, input int hold);
        for (int r = 0; r < runs; r++) begin
            bus.dec = 1'b0;
            tick($urandom_range(1, DB - 1));
            bus.dec = 1'b1;
            tick($urandom_range(1, DB - 1));
        end
        press_clean(hold, 10);
    endtask

    initial begin
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.dec   = 1'b1;
        bus.num   = '0;
`ifdef COUNTDOWN_AUTO_DEC_EN
        bus.auto_mode = 1'b0;
`endif
        tick(3);
        check_all("reset");
        rst = 1'b1;
        tick(2);

        // Load 15
        do_start(15);
        check_all("load15");

        // Clean press with exact latency: update on the 7th edge
        bus.dec = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            if (k == 6) check_eq("lat.before", 32'(bus.count), 32'd15);
            if (k == 7) check_eq("lat.after",  32'(bus.count), 32'd14);
        end
        tick(3);
        bus.dec = 1'b1;
        tick(12);
        m_press();
        check_all("release");

        // Bouncy press: toggle every 2 cycles for 12 cycles, then hold low
        for (int r = 0; r < 3; r++) begin
            bus.dec = 1'b0;
            tick(2);
            bus.dec = 1'b1;
            tick(2);
        end
        press_clean(10, 10);
        check_all("bouncy");

        // Terminal count on the same edge as the decrement
        do_start(1);
        bus.dec = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            if (k == 6) check_eq("term.pre_done", 32'(bus.done), 32'd0);
            if (k == 7) begin
                check_eq("term.count", 32'(bus.count), 32'd0);
                check_eq("term.done",  32'(bus.done),  32'd1);
            end
        end
        tick(3);
        bus.dec = 1'b1;
        tick(10);
        m_press();
        check_all("term");
        press_clean(10, 10);
        check_all("nowrap");

        // Zero preset: one cycle in RUN, then DONE
        bus.num   = 4'd0;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check_eq("zero.run_done", 32'(bus.done), 32'd0);
        tick(1);
        check_eq("zero.done", 32'(bus.done), 32'd1);
        m_cnt = 0;
        m_st  = 2;
        check_all("zero");

        // start coincident with dec_pulse at count 9: reload wins
        do_start(9);
        bus.dec = 1'b0;
        tick(6);
        bus.num   = 4'd12;
        bus.start = 1'b1;
        tick(1);
        check_eq("prio.reload", 32'(bus.count), 32'd12);
        bus.start = 1'b0;
        tick(1);
        check_eq("prio.hold", 32'(bus.count), 32'd12);
        tick(3);
        bus.dec = 1'b1;
        tick(10);
        m_cnt = 12;
        m_st  = 1;
        check_all("prio");

        // Asynchronous reset mid-RUN with a press in flight
        do_start(7);
        bus.dec = 1'b0;
        tick(3);
        #2 rst = 1'b0;
        #1;
        m_cnt = 0;
        m_st  = 0;
        check_all("async_rst");
        tick(2);
        rst = 1'b1;
        tick(10);
        bus.dec = 1'b1;
        tick(10);
        check_all("idle_ignore1");
        press_clean(10, 10);
        check_all("idle_ignore2");

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0:       do_start($urandom_range(0, 15));
                1, 2:    press_clean($urandom_range(DB + 4, DB + 8), $urandom_range(DB + 4, DB + 8));
                3:       press_bouncy($urandom_range(1, 4), $urandom_range(DB + 4, DB + 8));
                default: tick($urandom_range(1, 6));
            endcase
            check_all($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Clocked controller for the N-bit down-counter display datapath: loads a preset, sequences decrements from a physical push-button, detects terminal count, drives two 7-segment digits (tens/units).
- Replaces raw, unclocked button-driven decrementing with a synchronised, debounced, single-pulse-per-press scheme.
- Sits between board buttons/switches and the display pins.

Parameters:
- N, 4, counter width; legal range 1..6 (max value 63 fits two decimal digits).
- DB_CYCLES, 50000, cycles the synchronised button level must be stable before being accepted; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- start  input  1  synchronous level; when high, loads num and enters RUN.
- dec  input  1  raw push-button, active-low (pressed = 0), asynchronous and bouncy.
- num  input  N  preset value, sampled only on load.
- count  output  N  current counter value.
- done  output  1  high while in DONE.
- segA  output  7  tens digit, active-low, bit order gfedcba.
- segB  output  7  units digit, active-low, bit order gfedcba.

Behaviour:
- Reset (rst=0, async): state IDLE, count=0, done=0, debounce counter=0, debounced level=1.
- Reset outputs: segA=segB=7'b1000000 ("0").
- Input conditioning:
  - dec passes through a 2-FF synchroniser.
  - Debounce: a candidate level is accepted after DB_CYCLES consecutive equal samples; any change restarts the count.
  - dec_pulse is a 1-cycle pulse on the debounced 1->0 transition. Exactly one pulse per accepted press; release generates nothing.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> count<=num, go RUN. dec_pulse ignored.
  - RUN, start=1: reload num, stay in RUN. start has priority over a simultaneous dec_pulse.
  - RUN, count==0: go DONE next cycle (covers num=0 loads).
  - RUN, dec_pulse and count>0: count<=count-1. If the result is 0, go DONE in the same edge.
  - DONE: done=1, count held at 0, dec_pulse ignored (no wrap to 2^N-1). start=1 reloads and goes RUN.
- Latency:
  - Press to dec_pulse: 2 sync + DB_CYCLES cycles.
  - dec_pulse to count update: 1 edge.
  - count to seg outputs: combinational, same cycle.
- Display: tens=count/10, units=count%10 (constant-divisor logic, widths N). segA=decode(tens), segB=decode(units).
- Reset mid-debounce or mid-RUN: immediate return to reset values; an in-flight press is discarded.

Optional Feature:
- Macro: COUNTDOWN_AUTO_DEC_EN.
- Defined:
  - Adds parameter TICK_CYCLES (default 50_000_000) and input auto_mode (1 bit).
  - In RUN with auto_mode=1, a free-running prescaler emits a tick every TICK_CYCLES cycles; each tick decrements exactly like dec_pulse.
  - A tick and dec_pulse in the same cycle decrement by 1 only.
  - The prescaler clears on load and on entry to DONE.
- Undefined: no auto_mode port, no prescaler; behaviour identical to the base spec.

Decomposition:
- Package countdown_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - SEG_BLANK constant;
  - 10-entry active-low digit pattern constant array.
- One sub-module, seg7_decoder: 4-bit digit in, 7-bit active-low segments out; values >9 give SEG_BLANK. Instantiated twice.

Test Plan (bench uses DB_CYCLES=4):
- Reset, then num=15, start pulse -> count=15, segA=7'b1111001 ("1"), segB=7'b0010010 ("5"), done=0.
- Clean press (dec low 10 cycles, then high) -> exactly one decrement to 14, registered 7 cycles after the falling edge (2 sync + 4 stable + 1 update); release causes no change.
- Bouncy press (dec toggling every 2 cycles for 12 cycles, then held low) -> single decrement only.
- From count=1, press -> count=0, done=1 at the same edge. A further press keeps count=0, no wrap to 15.
- num=0 with start -> RUN one cycle, then DONE with done=1. start held with a simultaneous dec_pulse at count=9 -> count reloads num, no decrement.
- Assert rst=0 mid-RUN at count=7 -> count=0, done=0, segs "0" immediately (async). After rst=1, state is IDLE and presses are ignored.
